vram_scheduler: RTL and testbench
=================================

// Module: vram_scheduler
// PURPOSE
//  Time-slot scheduler for the single-port synchronous video RAM (1-cycle read latency) behind the 640x480 VGA timing.
//  Framebuffer is FB_W x FB_H, upscaled 4x in both axes; scanout needs one read per 4 pixels.
//  Scanout is guaranteed its slots; the remaining slots go to a frame-clear engine, then to the game-logic writer.
// PARAMETERS
//  FB_W 160 : framebuffer columns
//  FB_H 120 : framebuffer rows
//  PIX_W 8 : bits per framebuffer pixel
//  ADDR_W 15 : framebuffer address width (FB_W*FB_H <= 2**ADDR_W)
//  H_ACT_START 144 : first active pos_H
//  V_ACT_START 34 : first active pos_V
// PORTS
//  vga_CLK    in  1        pixel clock
//  vga_RST    in  1        synchronous active-high reset
//  pos_H      in  10       horizontal counter, 0..799
//  pos_V      in  10       vertical counter, 0..524
//  wr_req     in  1        writer request; wr_addr/wr_data held stable until wr_ack
//  wr_addr    in  ADDR_W   writer pixel address (row*FB_W+col)
//  wr_data    in  PIX_W    writer pixel value
//  wr_ack     out 1        1-cycle pulse: request consumed
//  wr_err     out 1        1-cycle pulse with wr_ack when wr_addr >= FB_W*FB_H (write dropped)
//  clr_req    in  1        start full-frame clear (pulse or level; sampled only when idle)
//  clr_color  in  PIX_W    fill value, captured on accept
//  clr_busy   out 1        clear in progress
//  mem_addr   out ADDR_W+1 registered RAM address; MSB = buffer select
//  mem_we     out 1        registered write enable
//  mem_wdata  out PIX_W    registered write data
//  mem_rdata  in  PIX_W    RAM read data, valid the cycle after the address is presented
//  pix_rgb    out PIX_W    scanout pixel; lags pos_H/pos_V by 1 cycle; 0 outside active area
// BEHAVIOUR
//  - Reset: all outputs 0; clear FSM in IDLE; pending requests dropped; front buffer 0. Reset mid-clear aborts the clear; RAM contents undefined.
//  - Active region: x=pos_H-144 in 0..639, y=pos_V-34 in 0..479.
//  - Scan slot: cycle where (x+2) mod 4 == 0, 0 <= x+2 <= 636 and y active, so pos_H = 142 + 4g.
//    Registers mem_addr = (y>>2)*FB_W + g, mem_we=0. The row multiply is computed as shift-add (128+32).
//  - Pipeline: addr presented during x=4g-1; mem_rdata valid during x=4g; latched into the pixel register at that edge.
//    pix_rgb therefore shows framebuffer pixel g while pos is x=4g+1..4g+4, i.e. a 1-cycle lag. Forced to 0 when the lagged position is inactive.
//  - Non-scan cycles go to the clear FSM if busy, else to the writer if wr_req. Otherwise mem_we=0 and mem_addr holds.
//  - Writer: on grant, mem_we=1, mem_addr/mem_wdata registered, and wr_ack pulses in the same cycle mem_we is asserted.
//    Out-of-range addresses: wr_ack+wr_err pulse, mem_we stays 0. At most one ack per request-hold.
//  - Clear FSM: IDLE -> CLEAR on clr_req (clr_busy=1 the next cycle); writes clr_color to addresses 0..FB_W*FB_H-1 in granted slots.
//    CLEAR -> IDLE after address FB_W*FB_H-1 is written; clr_busy drops the same cycle.
//    clr_req while busy: ignored. clr_req and wr_req together: clear wins, writer stalls until done.
//  - Writer worst-case wait outside a clear: 1 cycle (no two consecutive scan slots).
// CONFIGURATION
//  `VRAM_DOUBLE_BUFFER_EN defined:
//   - extra input swap_req (1) and output swap_done (1-cycle pulse).
//   - Scanout reads buffer `front`; writer and clear write buffer ~front (mem_addr MSB).
//   - A pending swap toggles `front` at pos_V==514, pos_H==0, only if clr_busy==0; otherwise it stays pending to the next frame. swap_done pulses on the toggle.
//  Not defined: single buffer, mem_addr MSB tied 0, no swap ports.
// STRUCTURE
//  vga_pkg: H/V active-start and end constants, FB_W/FB_H/PIX_W defaults, clear-FSM state enum {CLR_IDLE, CLR_RUN}.
//  Sub-module vram_clear_fsm: clear counter and state; interface start/color/grant -> busy/addr/data.
//  Slot decode, writer grant and the pixel pipeline stay in the top.
// TESTING
//  Fill RAM with addr[7:0] pattern, run one frame -> pos (144+4g+1,34) shows pix_rgb = g; row y=4..7 reads addr 160+g; blanking = 0.
//  wr_req addr=161 data=0xAA at pos_H=142 (scan slot) -> no grant that cycle; wr_ack next cycle, mem_we=1, mem_addr=161.
//  wr_req addr=19200 -> wr_ack & wr_err pulse, mem_we never 1.
//  clr_req color=0x3C with wr_req held -> writer stalls; 19200 writes of 0x3C; clr_busy falls; wr_ack follows.
//  vga_RST asserted mid-clear -> next cycle clr_busy=0, mem_we=0, pix_rgb=0; new clr_req restarts at addr 0.
//  DOUBLE_BUFFER_EN: swap_req at line 100 -> front toggles at (514,0), swap_done pulses; swap_req during clear -> toggle deferred.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer defaults and clear-FSM state type
// for the VGA video-RAM scheduler.
package vga_pkg;
  localparam int unsigned VGA_H_ACT_START = 144;
  localparam int unsigned VGA_H_ACT_END   = 784;
  localparam int unsigned VGA_V_ACT_START = 34;
  localparam int unsigned VGA_V_ACT_END   = 514;

  localparam int unsigned FB_W_DEF  = 160;
  localparam int unsigned FB_H_DEF  = 120;
  localparam int unsigned PIX_W_DEF = 8;

  typedef enum logic {CLR_IDLE, CLR_RUN} clr_state_t;
endpackage

// File: rtl/vram_clear_fsm.sv
// Frame-clear engine: walks addresses 0..DEPTH-1 writing a captured colour,
// advancing one address per granted memory slot.
module vram_clear_fsm
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned PIX_W  = PIX_W_DEF,
  parameter int unsigned DEPTH  = FB_W_DEF * FB_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  color,
  input  logic              grant,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  data
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_t        state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [PIX_W-1:0]  col, col_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLR_IDLE;
      cnt   <= '0;
      col   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      col   <= col_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    col_n   = col;
    case (state)
      CLR_IDLE: begin
        if (start) begin
          state_n = CLR_RUN;
          cnt_n   = '0;
          col_n   = color;
        end
      end
      CLR_RUN: begin
        if (grant) begin
          if (cnt == LAST) begin
            state_n = CLR_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = CLR_IDLE;
    endcase
  end

  assign busy = (state == CLR_RUN);
  assign addr = cnt;
  assign data = col;
endmodule

// File: rtl/vram_scheduler.sv
// Slot scheduler for the single-port video RAM behind 640x480 VGA scanout:
// scan reads first, then frame clear, then the game-logic writer.
// Optional double buffering: define VRAM_DOUBLE_BUFFER_EN.
module vram_scheduler
  import vga_pkg::*;
#(
  parameter int unsigned FB_W        = FB_W_DEF,
  parameter int unsigned FB_H        = FB_H_DEF,
  parameter int unsigned PIX_W       = PIX_W_DEF,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned H_ACT_START = VGA_H_ACT_START,
  parameter int unsigned V_ACT_START = VGA_V_ACT_START
) (
  input  logic              vga_CLK,
  input  logic              vga_RST,
  input  logic [9:0]        pos_H,
  input  logic [9:0]        pos_V,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              clr_req,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              clr_busy,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_rgb
`ifdef VRAM_DOUBLE_BUFFER_EN
  ,
  input  logic              swap_req,
  output logic              swap_done
`endif
);
  localparam int unsigned H_LEN = VGA_H_ACT_END - VGA_H_ACT_START;
  localparam int unsigned V_LEN = VGA_V_ACT_END - VGA_V_ACT_START;
  localparam logic [9:0] H_FIRST    = 10'(H_ACT_START);
  localparam logic [9:0] H_LAST     = 10'(H_ACT_START + H_LEN - 1);
  localparam logic [9:0] V_FIRST    = 10'(V_ACT_START);
  localparam logic [9:0] V_LAST     = 10'(V_ACT_START + V_LEN - 1);
  localparam logic [9:0] SCAN_FIRST = 10'(H_ACT_START - 2);
  localparam logic [9:0] SCAN_LAST  = 10'(H_ACT_START + H_LEN - 6);
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_W * FB_H - 1);

  logic              h_act, v_act, scan;
  logic [1:0]        phase;
  logic [7:0]        row, col;
  logic [ADDR_W-1:0] row_base, scan_addr;
  logic              clr_grant, wr_grant, wr_oor;
  logic [ADDR_W-1:0] clr_addr;
  logic [PIX_W-1:0]  clr_data;
  logic              sbuf, wbuf;

  assign h_act = (pos_H >= H_FIRST) && (pos_H <= H_LAST);
  assign v_act = (pos_V >= V_FIRST) && (pos_V <= V_LAST);
  // phase counts from two pixels before x=0 so a read issued at phase 0 lands at x=4g
  assign phase = 2'(pos_H - SCAN_FIRST);
  assign col   = 8'((pos_H - SCAN_FIRST) >> 2);
  assign row   = 8'((pos_V - V_FIRST) >> 2);
  assign scan  = v_act && (pos_H >= SCAN_FIRST) && (pos_H <= SCAN_LAST) && (phase == 2'd0);

  if (FB_W == 160) begin : g_row160
    assign row_base = (ADDR_W'(row) << 7) + (ADDR_W'(row) << 5);
  end else begin : g_rowmul
    assign row_base = ADDR_W'(row * FB_W);
  end
  assign scan_addr = row_base + ADDR_W'(col);

  assign wr_oor    = (wr_addr > FB_LAST);
  assign clr_grant = !scan && clr_busy;
  // clr_req also blocks the writer so a simultaneous clear request wins
  assign wr_grant  = !scan && !clr_busy && !clr_req && wr_req && !wr_ack;

  vram_clear_fsm #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W),
    .DEPTH  (FB_W * FB_H)
  ) u_clear (
    .clk   (vga_CLK),
    .rst   (vga_RST),
    .start (clr_req),
    .color (clr_color),
    .grant (clr_grant),
    .busy  (clr_busy),
    .addr  (clr_addr),
    .data  (clr_data)
  );

`ifdef VRAM_DOUBLE_BUFFER_EN
  localparam logic [9:0] V_SWAP = 10'(V_ACT_START + V_LEN);
  logic front, swap_pend;

  always_ff @(posedge vga_CLK) begin
    if (vga_RST) begin
      front     <= 1'b0;
      swap_pend <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      if ((swap_pend || swap_req) && pos_V == V_SWAP && pos_H == '0 && !clr_busy) begin
        front     <= ~front;
        swap_pend <= 1'b0;
        swap_done <= 1'b1;
      end else if (swap_req) begin
        swap_pend <= 1'b1;
      end
    end
  end
  assign sbuf = front;
  assign wbuf = ~front;
`else
  assign sbuf = 1'b0;
  assign wbuf = 1'b0;
`endif

  always_ff @(posedge vga_CLK) begin
    if (vga_RST) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      pix_rgb   <= '0;
    end else begin
      mem_we <= 1'b0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      if (scan) begin
        mem_addr <= {sbuf, scan_addr};
      end else if (clr_grant) begin
        mem_addr  <= {wbuf, clr_addr};
        mem_we    <= 1'b1;
        mem_wdata <= clr_data;
      end else if (wr_grant) begin
        wr_ack <= 1'b1;
        if (wr_oor) begin
          wr_err <= 1'b1;
        end else begin
          mem_addr  <= {wbuf, wr_addr};
          mem_we    <= 1'b1;
          mem_wdata <= wr_data;
        end
      end

      if (!(h_act && v_act)) begin
        pix_rgb <= '0;
      end else if (phase == 2'd2) begin
        pix_rgb <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_vram_scheduler.sv
// Directed bench for vram_scheduler: scanout pixels, writer grant timing,
// out-of-range writes, frame clear, reset abort and (optionally) buffer swap.
module tb_vram_scheduler;
  logic        vga_CLK = 1'b0;
  logic        vga_RST;
  logic [9:0]  pos_H, pos_V;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack, wr_err;
  logic        clr_req;
  logic [7:0]  clr_color;
  logic        clr_busy;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  pix_rgb;
`ifdef VRAM_DOUBLE_BUFFER_EN
  logic        swap_req, swap_done;
  localparam logic WB = 1'b1;
`else
  localparam logic WB = 1'b0;
`endif

  logic [7:0] vram [0:65535];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 vga_CLK = ~vga_CLK;

  always @(posedge vga_CLK) begin
    if (mem_we) vram[mem_addr] <= mem_wdata;
    mem_rdata <= vram[mem_addr];
  end

  vram_scheduler dut (
    .vga_CLK   (vga_CLK),
    .vga_RST   (vga_RST),
    .pos_H     (pos_H),
    .pos_V     (pos_V),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .wr_err    (wr_err),
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_rgb   (pix_rgb)
`ifdef VRAM_DOUBLE_BUFFER_EN
    ,
    .swap_req  (swap_req),
    .swap_done (swap_done)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (pos %0d,%0d)", tag, got, exp, pos_H, pos_V);
    end
  endtask

  task automatic set_pos(input int h, input int v);
    pos_H = 10'(h);
    pos_V = 10'(v);
  endtask

  // One clock: outputs now reflect the position held before the edge.
  task automatic step();
    @(posedge vga_CLK);
    #1;
    if (pos_H == 10'd799) begin
      pos_H = '0;
      pos_V = (pos_V == 10'd524) ? '0 : pos_V + 1'b1;
    end else begin
      pos_H = pos_H + 1'b1;
    end
  endtask

  task automatic run_line(input int v, input int base);
    int h;
    set_pos(130, v);
    for (int i = 0; i < 660; i++) begin
      step();
      h = int'(pos_H);
      if (h == 143) begin
        check("scan_addr", mem_addr, 32'(base));
        check("scan_we", mem_we, 0);
      end
      if (h == 144 || h == 786) check("pix_edge", pix_rgb, 0);
      if (h >= 145 && h <= 781 && ((h - 145) % 4) == 0)
        check("pix", pix_rgb, 32'((base + (h - 145) / 4) & 8'hFF));
    end
  endtask

  initial begin
    int unsigned cnt, bad;
    logic done, got;

    for (int a = 0; a < 65536; a++) vram[a] = 8'(a);
    vga_RST = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    clr_req = 1'b0; clr_color = '0; set_pos(0, 0);
`ifdef VRAM_DOUBLE_BUFFER_EN
    swap_req = 1'b0;
`endif
    repeat (3) step();
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_ack", wr_ack, 0);
    check("rst_busy", clr_busy, 0);
    check("rst_pix", pix_rgb, 0);
    vga_RST = 1'b0;

    // scanout: row y=0 and row y=4, plus a blanking line
    run_line(34, 0);
    run_line(38, 160);
    set_pos(130, 20);
    for (int i = 0; i < 200; i++) begin
      step();
      if (pos_H == 10'd149) check("pix_vblank", pix_rgb, 0);
    end

    // writer request arrives on a scan slot
    set_pos(142, 40);
    wr_req = 1'b1; wr_addr = 15'd161; wr_data = 8'hAA;
    step();
    check("wr_scan_ack", wr_ack, 0);
    check("wr_scan_we", mem_we, 0);
    step();
    check("wr_ack", wr_ack, 1);
    check("wr_we", mem_we, 1);
    check("wr_addr", mem_addr, {WB, 15'd161});
    check("wr_data", mem_wdata, 8'hAA);
    wr_req = 1'b0;
    step();
    check("wr_ack_pulse", wr_ack, 0);
    check("wr_ram", vram[{WB, 15'd161}], 8'hAA);

    // out-of-range write is dropped
    set_pos(10, 200);
    wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 8'h55;
    step();
    check("oor_ack", wr_ack, 1);
    check("oor_err", wr_err, 1);
    got = mem_we;
    wr_req = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); got = got | mem_we; end
    check("oor_we", got, 0);
    check("oor_err_pulse", wr_err, 0);

    // clear with a writer held at the same time
    set_pos(600, 33);
    clr_req = 1'b1; clr_color = 8'h3C;
    wr_req = 1'b1; wr_addr = 15'd500; wr_data = 8'h11;
    step();
    check("clr_start_busy", clr_busy, 1);
    check("clr_start_ack", wr_ack, 0);
    clr_req = 1'b0;
    cnt = 0; bad = 0; done = 1'b0;
    for (int i = 0; i < 30000 && !done; i++) begin
      step();
      if (wr_ack) bad++;
      if (mem_we) begin
        if (mem_wdata == 8'h3C && mem_addr == {WB, 15'(cnt)}) cnt++;
        else bad++;
      end
      if (!clr_busy) done = 1'b1;
    end
    check("clr_done", done, 1);
    check("clr_writes", cnt, 19200);
    check("clr_bad", bad, 0);
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      if (wr_ack) got = 1'b1;
    end
    check("wr_after_clr", got, 1);
    check("wr_after_clr_addr", mem_addr, {WB, 15'd500});
    check("wr_after_clr_data", mem_wdata, 8'h11);
    wr_req = 1'b0;
    step();
    check("clr_ram_last", vram[{WB, 15'd19199}], 8'h3C);
    check("wr_ram_500", vram[{WB, 15'd500}], 8'h11);

    // reset in the middle of a clear, then restart
    set_pos(300, 100);
    clr_req = 1'b1; clr_color = 8'h55;
    step();
    clr_req = 1'b0;
    repeat (100) step();
    check("mid_busy", clr_busy, 1);
    vga_RST = 1'b1;
    step();
    check("abort_busy", clr_busy, 0);
    check("abort_we", mem_we, 0);
    check("abort_pix", pix_rgb, 0);
    vga_RST = 1'b0;
    clr_req = 1'b1; clr_color = 8'h66;
    step();
    clr_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      step();
      if (mem_we) got = 1'b1;
    end
    check("restart_we", got, 1);
    check("restart_addr", mem_addr, {WB, 15'd0});
    check("restart_data", mem_wdata, 8'h66);
    vga_RST = 1'b1;
    step();
    vga_RST = 1'b0;

`ifdef VRAM_DOUBLE_BUFFER_EN
    // plain swap at the end of the active frame
    set_pos(0, 100);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    check("swap_early", swap_done, 0);
    set_pos(798, 513);
    step(); step();
    check("swap_before", swap_done, 0);
    step();
    check("swap_done", swap_done, 1);
    step();
    check("swap_pulse", swap_done, 0);
    set_pos(142, 34);
    step();
    check("swap_scan_buf", mem_addr, 32'h8000);

    // swap requested during a clear is deferred
    set_pos(700, 513);
    clr_req = 1'b1; clr_color = 8'h77;
    step();
    clr_req = 1'b0; swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (swap_done) got = 1'b1;
    end
    check("swap_deferred", got, 0);
    check("swap_def_busy", clr_busy, 1);
    done = 1'b0;
    for (int i = 0; i < 30000 && !done; i++) begin
      step();
      if (!clr_busy) done = 1'b1;
    end
    check("db_clr_done", done, 1);
    check("db_clr_buf0", vram[16'h0000], 8'h77);
    set_pos(0, 514);
    step();
    check("swap_late", swap_done, 1);
    set_pos(142, 34);
    step();
    check("swap_back_buf", mem_addr, 32'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
